maxpool_ctrl: RTL and testbench

Sequencer and stream front-end for the MVU max-pool datapath. It accepts a valid/ready stream of signed N-bit values, splits it into windows of `win_len` elements, and drives the datapath's clear, pool-enable and input lines. It returns one pooled maximum per window on a valid/ready output stream, for `num_win` windows per job. It sits between the MVU output scaler and the output writeback path and runs opposite to the datapath: it produces the datapath's control signals and consumes its result.

---
 rtl/maxpool_pkg.sv | 14 +
 rtl/maxpool_dp.sv | 27 ++
 rtl/maxpool_ctrl.sv | 138 +++++++++++++
 tb/tb_maxpool_ctrl.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/maxpool_pkg.sv
// Shared types and default widths for the max-pool sequencer and its datapath.
package maxpool_pkg;

    localparam int N_DEF    = 32;
    localparam int CNTW_DEF = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FIRST = 2'd1,
        ST_ACC   = 2'd2,
        ST_EMIT  = 2'd3
    } state_t;

endpackage

// File: rtl/maxpool_dp.sv
// Max-pool datapath: one register, cleared, loaded, or updated with max(O, I).
module maxpool_dp #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_clr,
    input  logic         i_en,
    input  logic [N-1:0] i_data,
    output logic [N-1:0] o_data
);

    logic [N-1:0] r_o;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_o <= '0;
        end else if (i_clr) begin
            r_o <= '0;
        end else if (!i_en || ($signed(i_data) > $signed(r_o))) begin
            r_o <= i_data;
        end
    end

    assign o_data = r_o;

endmodule

// File: rtl/maxpool_ctrl.sv
// Sequencer for the max-pool datapath: windows an input stream, drives clear/enable/input,
// and returns one pooled maximum per window on a valid/ready output stream.
module maxpool_ctrl
    import maxpool_pkg::*;
#(
    parameter int N    = N_DEF,
    parameter int CNTW = CNTW_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            i_start,
    input  logic            i_abort,
    input  logic [CNTW-1:0] i_win_len,
    input  logic [CNTW-1:0] i_num_win,
    output logic            o_busy,
    output logic            o_done,
    input  logic            i_in_valid,
    output logic            o_in_ready,
    input  logic [N-1:0]    i_in_data,
    output logic            o_out_valid,
    input  logic            i_out_ready,
    output logic [N-1:0]    o_out_data,
    output logic            o_pool_clr,
    output logic            o_pool_en,
    output logic [N-1:0]    o_pool_i,
    input  logic [N-1:0]    i_pool_o,
    output logic [1:0]      o_dbg_state
);

    // Streams use strict valid/ready: a beat is valid & ready on a rising edge; once
    // out_valid is high, it and out_data hold until the beat completes.

    state_t          r_state;
    logic [CNTW-1:0] r_win_len;
    logic [CNTW-1:0] r_num_win;
    logic [CNTW-1:0] r_elem_cnt;
    logic [CNTW-1:0] r_win_cnt;
    logic            r_done;

    logic [CNTW-1:0] w_elem_nxt;
    logic [CNTW-1:0] w_win_nxt;

    assign w_elem_nxt  = r_elem_cnt + CNTW'(1);
    assign w_win_nxt   = r_win_cnt + CNTW'(1);

    assign o_busy      = (r_state != ST_IDLE);
    assign o_done      = r_done;
    assign o_in_ready  = (r_state == ST_FIRST) || (r_state == ST_ACC);
    assign o_out_valid = (r_state == ST_EMIT);
    assign o_out_data  = i_pool_o;
    assign o_pool_clr  = (r_state == ST_IDLE);
    assign o_dbg_state = r_state;

    // The datapath has no enable, so a stall re-feeds its own output through max().
    always_comb begin
        o_pool_en = 1'b1;
        o_pool_i  = i_pool_o;
        case (r_state)
            ST_IDLE: begin
                o_pool_en = 1'b0;
                o_pool_i  = '0;
            end
            ST_FIRST: begin
                if (i_in_valid) begin
                    o_pool_en = 1'b0;
                    o_pool_i  = i_in_data;
                end
            end
            ST_ACC: begin
                if (i_in_valid) begin
                    o_pool_i = i_in_data;
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_win_len  <= '0;
            r_num_win  <= '0;
            r_elem_cnt <= '0;
            r_win_cnt  <= '0;
            r_done     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (i_abort) begin
                r_state <= ST_IDLE;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (i_start) begin
                            r_win_len  <= (i_win_len == '0) ? CNTW'(1) : i_win_len;
                            r_num_win  <= i_num_win;
                            r_elem_cnt <= '0;
                            r_win_cnt  <= '0;
                            if (i_num_win == '0) begin
                                r_done <= 1'b1;
                            end else begin
                                r_state <= ST_FIRST;
                            end
                        end
                    end
                    ST_FIRST: begin
                        if (i_in_valid) begin
                            r_elem_cnt <= CNTW'(1);
                            r_state    <= (r_win_len == CNTW'(1)) ? ST_EMIT : ST_ACC;
                        end
                    end
                    ST_ACC: begin
                        if (i_in_valid) begin
                            r_elem_cnt <= w_elem_nxt;
                            if (w_elem_nxt == r_win_len) begin
                                r_state <= ST_EMIT;
                            end
                        end
                    end
                    ST_EMIT: begin
                        if (i_out_ready) begin
                            r_win_cnt <= w_win_nxt;
                            if (w_win_nxt == r_num_win) begin
                                r_state <= ST_IDLE;
                                r_done  <= 1'b1;
                            end else begin
                                r_state    <= ST_FIRST;
                                r_elem_cnt <= '0;
                            end
                        end
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_maxpool_ctrl.sv
// Bench for maxpool_ctrl wired to maxpool_dp; expected maxima come from a window model.
module tb_maxpool_ctrl;
    import maxpool_pkg::*;

    localparam int N    = N_DEF;
    localparam int CNTW = CNTW_DEF;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            start = 1'b0;
    logic            abort = 1'b0;
    logic [CNTW-1:0] win_len = '0;
    logic [CNTW-1:0] num_win = '0;
    logic            busy, done;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [N-1:0]    in_data = '0;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic [N-1:0]    out_data;
    logic            pool_clr, pool_en;
    logic [N-1:0]    pool_i, pool_o;
    logic [1:0]      dbg_state;

    int              n_checks = 0;
    int              n_fail = 0;
    logic [N-1:0]    exp_q[$];
    int              stim_q[$];

    maxpool_ctrl #(.N(N), .CNTW(CNTW)) dut (
        .clk(clk), .rst_n(rst_n), .i_start(start), .i_abort(abort),
        .i_win_len(win_len), .i_num_win(num_win), .o_busy(busy), .o_done(done),
        .i_in_valid(in_valid), .o_in_ready(in_ready), .i_in_data(in_data),
        .o_out_valid(out_valid), .i_out_ready(out_ready), .o_out_data(out_data),
        .o_pool_clr(pool_clr), .o_pool_en(pool_en), .o_pool_i(pool_i),
        .i_pool_o(pool_o), .o_dbg_state(dbg_state)
    );

    maxpool_dp #(.N(N)) u_dp (
        .clk(clk), .rst_n(rst_n), .i_clr(pool_clr), .i_en(pool_en),
        .i_data(pool_i), .o_data(pool_o)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, $signed(obs), $signed(exp));
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference: each window's result is the signed maximum of its elements.
    task automatic build_expected(input int wl, input int nw);
        int eff;
        int m;
        eff = (wl == 0) ? 1 : wl;
        exp_q.delete();
        for (int w = 0; w < nw; w++) begin
            m = stim_q[w * eff];
            for (int k = 1; k < eff; k++) begin
                if (stim_q[w * eff + k] > m) m = stim_q[w * eff + k];
            end
            exp_q.push_back(N'(m));
        end
    endtask

    task automatic run_job(input int wl, input int nw, input int gmin, input int gmax,
                           input int smin, input int smax);
        int           idx;
        int           gap;
        int           stall;
        int           cyc;
        logic         fin;
        logic         in_beat;
        logic         out_beat;
        logic         was_busy;
        logic         ov_before;
        logic         prev_hold;
        logic [N-1:0] prev_data;
        logic [N-1:0] held;
        build_expected(wl, nw);
        win_len = CNTW'(wl);
        num_win = CNTW'(nw);
        start = 1'b1;
        step();
        start = 1'b0;
        check("busy_after_start", busy, 1'b1);
        idx = 0;
        gap = 0;
        stall = $urandom_range(smax, smin);
        cyc = 0;
        fin = 1'b0;
        prev_hold = 1'b0;
        prev_data = '0;
        while (!fin && cyc < 3000) begin
            if (idx < stim_q.size() && gap == 0) begin
                in_valid = 1'b1;
                in_data  = N'(stim_q[idx]);
            end else begin
                in_valid = 1'b0;
                in_data  = N'(100);
            end
            out_ready = (stall == 0);
            in_beat   = in_valid && in_ready;
            out_beat  = out_valid && out_ready;
            if (prev_hold) begin
                check("out_valid_stable", out_valid, 1'b1);
                check("out_data_stable", out_data, prev_data);
            end
            check("done_low_mid_job", done, 1'b0);
            if (out_beat) begin
                if (exp_q.size() == 0) check("unexpected_output", out_valid, 1'b0);
                else check("out_data", out_data, exp_q.pop_front());
            end
            held      = pool_o;
            was_busy  = busy;
            ov_before = out_valid;
            prev_hold = out_valid && !out_ready;
            prev_data = out_data;
            step();
            if (was_busy && !in_beat) check("pool_hold", pool_o, held);
            if (in_beat) begin
                idx++;
                gap = $urandom_range(gmax, gmin);
            end else if (!in_valid && gap > 0) begin
                gap--;
            end
            if (out_beat) stall = $urandom_range(smax, smin);
            else if (ov_before && stall > 0) stall--;
            if (out_beat && exp_q.size() == 0) begin
                fin = 1'b1;
                check("done_pulse", done, 1'b1);
                check("busy_fall", busy, 1'b0);
            end
            cyc++;
        end
        check("job_finished", fin, 1'b1);
        check("exp_q_empty", N'(exp_q.size()), '0);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        step();
        check("done_one_cycle", done, 1'b0);
        check("idle_clr", pool_clr, 1'b1);
    endtask

    initial begin
        int wl;
        int nw;
        int eff;
        #1;
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_in_ready", in_ready, 1'b0);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_pool_clr", pool_clr, 1'b1);
        check("rst_pool_en", pool_en, 1'b0);
        check("rst_pool_i", pool_i, '0);
        step();
        rst_n = 1'b1;
        step();

        // Basic window
        stim_q = '{3, -7, 9, 2};
        run_job(4, 1, 0, 0, 0, 0);

        // All-negative window must not report the cleared 0
        stim_q = '{-5, -2, -8};
        run_job(3, 1, 0, 0, 0, 0);

        // Input gaps of 2 cycles and 3 cycles of output backpressure
        stim_q = '{1, 6, 4, 5};
        run_job(4, 1, 2, 2, 3, 3);

        // Single-element windows, and win_len 0 behaving as 1
        stim_q = '{-1, 0, 7};
        run_job(1, 3, 0, 0, 0, 0);
        stim_q = '{-1, 0, 7};
        run_job(0, 3, 0, 0, 0, 0);

        // Zero windows
        win_len = 8'd4;
        num_win = 8'd0;
        start = 1'b1;
        step();
        start = 1'b0;
        check("zero_done", done, 1'b1);
        check("zero_busy", busy, 1'b0);
        check("zero_out_valid", out_valid, 1'b0);
        step();
        check("zero_done_clear", done, 1'b0);
        check("zero_busy_after", busy, 1'b0);

        // Asynchronous reset in the middle of a window
        win_len = 8'd4;
        num_win = 8'd1;
        start = 1'b1;
        step();
        start = 1'b0;
        in_valid = 1'b1;
        in_data = N'(5);
        step();
        in_data = N'(6);
        step();
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_busy", busy, 1'b0);
        check("arst_in_ready", in_ready, 1'b0);
        check("arst_out_valid", out_valid, 1'b0);
        check("arst_pool_clr", pool_clr, 1'b1);
        check("arst_pool_en", pool_en, 1'b0);
        check("arst_pool_i", pool_i, '0);
        check("arst_pool_o", pool_o, '0);
        step();
        rst_n = 1'b1;
        step();
        stim_q = '{8, 8, 8, 8};
        run_job(4, 1, 0, 0, 0, 0);

        // Abort while a result is pending in EMIT
        win_len = 8'd2;
        num_win = 8'd2;
        start = 1'b1;
        step();
        start = 1'b0;
        in_valid = 1'b1;
        in_data = N'(3);
        step();
        in_data = N'(4);
        step();
        in_valid = 1'b0;
        out_ready = 1'b0;
        check("abort_pre_valid", out_valid, 1'b1);
        check("abort_pre_data", out_data, N'(4));
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("abort_busy", busy, 1'b0);
        check("abort_out_valid", out_valid, 1'b0);
        check("abort_done", done, 1'b0);
        step();
        check("abort_no_done_later", done, 1'b0);

        // Abort beats start in IDLE
        win_len = 8'd2;
        num_win = 8'd1;
        start = 1'b1;
        abort = 1'b1;
        step();
        start = 1'b0;
        abort = 1'b0;
        check("abort_wins_busy", busy, 1'b0);
        check("abort_wins_done", done, 1'b0);

        // Randomized jobs
        for (int j = 0; j < 25; j++) begin
            wl = $urandom_range(6, 0);
            nw = $urandom_range(4, 1);
            eff = (wl == 0) ? 1 : wl;
            stim_q.delete();
            for (int k = 0; k < eff * nw; k++) begin
                if ($urandom_range(3, 0) == 0) stim_q.push_back(int'($urandom));
                else stim_q.push_back($urandom_range(40, 0) - 20);
            end
            run_job(wl, nw, 0, 2, 0, 3);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
